// File: rtl/tt_check_pkg.sv
// Shared types and constants for the truth-table response checker.
package tt_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    // Width of a down-counter that must hold values 0..n.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tt_response_checker_if.sv
// Bus between the truth-table checker and its controller/DUT wrapper.
interface tt_response_checker_if #(
    parameter int N_IN = 4
);
    logic                 start;
    logic [2**N_IN-1:0]   expected;
    logic                 dut_out;
    logic [N_IN-1:0]      dut_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [N_IN:0]        err_count;
    logic [N_IN-1:0]      first_err;
    logic                 first_err_vld;
    logic [2**N_IN-1:0]   captured;

    modport master (
        output start, expected, dut_out,
        input  dut_in, busy, done, pass, err_count, first_err, first_err_vld, captured
    );

    modport slave (
        input  start, expected, dut_out,
        output dut_in, busy, done, pass, err_count, first_err, first_err_vld, captured
    );
endinterface

// File: rtl/tt_check_misr.sv
// 16-bit single-input MISR (x^16+x^12+x^5+1), MSB-first feedback, reseeded by init.
module tt_check_misr
    import tt_check_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        shift_en,
    input  logic        din,
    output logic [15:0] sig
);

    logic fb;
    assign fb = sig[15] ^ din;

    always_ff @(posedge clk) begin
        if (reset) begin
            sig <= '0;
        end else if (init) begin
            sig <= MISR_SEED;
        end else if (shift_en) begin
            sig <= {sig[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/tt_response_checker.sv
// Sweeps all 2**N_IN inputs of a combinational DUT, captures its truth table and grades it.
// Optional MISR signature output: define TT_RESPONSE_CHECKER_MISR_EN.
module tt_response_checker
    import tt_check_pkg::*;
#(
    parameter int N_IN       = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    tt_response_checker_if.slave  bus
`ifdef TT_RESPONSE_CHECKER_MISR_EN
    ,
    output logic [15:0]           signature
`endif
);

    localparam int              DEPTH    = 2**N_IN;
    localparam int              CNT_W    = cnt_width(SETTLE_CYC);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(DEPTH - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   settle_cnt;
    logic [N_IN-1:0]    idx;
    logic [DEPTH-1:0]   expected_q;
    logic [DEPTH-1:0]   captured_q;
    logic [N_IN:0]      err_count_q;
    logic [N_IN-1:0]    first_err_q;
    logic               first_err_vld_q;
    logic               pass_q;
    logic               accept;
    logic               miss;
    logic               last;
    logic               busy_c;
    logic               done_c;

    // start is only honoured from IDLE; the DONE cycle deliberately drops it.
    assign accept = (state == IDLE) && bus.start;
    assign miss   = bus.dut_out != expected_q[idx];
    assign last   = idx == LAST_IDX;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = SETTLE;
            end
            SETTLE: begin
                busy_c = 1'b1;
                if (settle_cnt == CNT_W'(1)) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                busy_c    = 1'b1;
                state_nxt = last ? DONE : SETTLE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // idx doubles as the registered DUT drive; it only moves on the SETTLE entry edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt      <= '0;
            idx             <= '0;
            expected_q      <= '0;
            captured_q      <= '0;
            err_count_q     <= '0;
            first_err_q     <= '0;
            first_err_vld_q <= 1'b0;
            pass_q          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        expected_q      <= bus.expected;
                        idx             <= '0;
                        captured_q      <= '0;
                        err_count_q     <= '0;
                        first_err_q     <= '0;
                        first_err_vld_q <= 1'b0;
                        pass_q          <= 1'b0;
                        settle_cnt      <= CNT_W'(SETTLE_CYC);
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 1'b1;
                end
                SAMPLE: begin
                    captured_q[idx] <= bus.dut_out;
                    if (miss) begin
                        err_count_q <= err_count_q + 1'b1;
                        if (!first_err_vld_q) begin
                            first_err_q     <= idx;
                            first_err_vld_q <= 1'b1;
                        end
                    end
                    if (last) begin
                        pass_q <= (err_count_q == '0) && !miss;
                    end else begin
                        idx        <= idx + 1'b1;
                        settle_cnt <= CNT_W'(SETTLE_CYC);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dut_in        = idx;
    assign bus.busy          = busy_c;
    assign bus.done          = done_c;
    assign bus.pass          = pass_q;
    assign bus.err_count     = err_count_q;
    assign bus.first_err     = first_err_q;
    assign bus.first_err_vld = first_err_vld_q;
    assign bus.captured      = captured_q;

`ifdef TT_RESPONSE_CHECKER_MISR_EN
    tt_check_misr u_misr (
        .clk      (clk),
        .reset    (reset),
        .init     (accept),
        .shift_en (state == SAMPLE),
        .din      (bus.dut_out),
        .sig      (signature)
    );
`endif

endmodule

// File: tb/tb_tt_response_checker.sv
// Bench for tt_response_checker: vector table on a 3-input instance plus hand-written corner sequences.
module tb_tt_response_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] fsel = 2'd0;

    always #5 clk = ~clk;

    tt_response_checker_if #(.N_IN(3)) if3 ();
    tt_response_checker_if #(.N_IN(4)) if4 ();

`ifdef TT_RESPONSE_CHECKER_MISR_EN
    logic [15:0] sig3, sig4;
`endif

    tt_response_checker #(.N_IN(3), .SETTLE_CYC(1)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3)
`ifdef TT_RESPONSE_CHECKER_MISR_EN
        , .signature (sig3)
`endif
    );

    tt_response_checker #(.N_IN(4), .SETTLE_CYC(3)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
`ifdef TT_RESPONSE_CHECKER_MISR_EN
        , .signature (sig4)
`endif
    );

    // Behavioural gates_* stand-ins; dut_in = {A,B,C}.
    always_comb begin
        case (fsel)
            2'd0:    if3.dut_out = (if3.dut_in[2] & if3.dut_in[1]) | if3.dut_in[0];
            2'd1:    if3.dut_out = 1'b0;
            2'd2:    if3.dut_out = 1'b1;
            default: if3.dut_out = if3.dut_in[2] ^ if3.dut_in[1] ^ if3.dut_in[0];
        endcase
    end
    assign if4.dut_out = 1'b0;

    typedef struct {
        logic [1:0] fsel;
        logic [7:0] expv;
        logic [7:0] cap;
        logic [3:0] errc;
        logic [2:0] ferr;
        logic       fev;
        logic       pass;
    } vec_t;

    typedef struct {
        logic [7:0] cap;
        logic [3:0] errc;
        logic [2:0] ferr;
        logic       fev;
        logic       pass;
    } result_t;

    vec_t    vecs[8];
    result_t sb[$];
    int      checks = 0;
    int      errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

`ifdef TT_RESPONSE_CHECKER_MISR_EN
    logic [15:0] first_sig;

    function automatic logic [15:0] misr_model(input logic [7:0] cap);
        logic [15:0] s;
        logic        fb;
        s = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            fb = s[15] ^ cap[i];
            s  = s << 1;
            if (fb) begin
                s[0]  = ~s[0];
                s[5]  = ~s[5];
                s[12] = ~s[12];
            end
        end
        return s;
    endfunction
`endif

    // Called at a negedge; returns at the negedge of the cycle after done.
    task automatic run3(input vec_t v, input bit noise, input bit chk_clear);
        result_t r;
        int      cyc;
        bit      seq_ok;
        bit      clr_ok;
        fsel         = v.fsel;
        if3.expected = v.expv;
        if3.start    = 1'b1;
        r.cap  = v.cap;
        r.errc = v.errc;
        r.ferr = v.ferr;
        r.fev  = v.fev;
        r.pass = v.pass;
        sb.push_back(r);
        @(negedge clk);
        if3.start = 1'b0;
        cyc    = 1;
        seq_ok = 1'b1;
        clr_ok = 1'b1;
        while (!if3.done && cyc < 200) begin
            if (cyc == 1)
                clr_ok = (if3.captured == 8'h00) && (if3.err_count == 4'd0) &&
                         !if3.first_err_vld && !if3.pass;
            if (if3.dut_in !== 3'((cyc - 1) / 2) || !if3.busy) seq_ok = 1'b0;
            if (noise) begin
                if3.start    = (cyc == 5) || (cyc == 12);
                if3.expected = ~v.expv;
            end
            @(negedge clk);
            cyc++;
        end
        if (noise) if3.start = 1'b1;
        check("latency", cyc, 17);
        check("dut_in_seq", seq_ok, 1);
        if (chk_clear) check("cleared_on_start", clr_ok, 1);
        check("busy_in_done", if3.busy, 0);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            r = sb.pop_front();
            check("captured", if3.captured, r.cap);
            check("err_count", if3.err_count, r.errc);
            check("first_err", if3.first_err, r.ferr);
            check("first_err_vld", if3.first_err_vld, r.fev);
            check("pass", if3.pass, r.pass);
        end
`ifdef TT_RESPONSE_CHECKER_MISR_EN
        check("signature", sig3, misr_model(v.cap));
`endif
        @(negedge clk);
        if3.start    = 1'b0;
        if3.expected = v.expv;
        check("done_single_pulse", if3.done, 0);
        check("idle_after_done", if3.busy, 0);
        check("pass_hold", if3.pass, v.pass);
        check("captured_hold", if3.captured, v.cap);
    endtask

    initial begin
        int  cyc;
        bit  ok;
        vecs[0] = '{2'd0, 8'hEA, 8'hEA, 4'd0, 3'd0, 1'b0, 1'b1};
        vecs[1] = '{2'd0, 8'hEB, 8'hEA, 4'd1, 3'd0, 1'b1, 1'b0};
        vecs[2] = '{2'd0, 8'h00, 8'hEA, 4'd5, 3'd1, 1'b1, 1'b0};
        vecs[3] = '{2'd3, 8'h96, 8'h96, 4'd0, 3'd0, 1'b0, 1'b1};
        vecs[4] = '{2'd3, 8'h69, 8'h96, 4'd8, 3'd0, 1'b1, 1'b0};
        vecs[5] = '{2'd2, 8'h7F, 8'hFF, 4'd1, 3'd7, 1'b1, 1'b0};
        vecs[6] = '{2'd1, 8'h00, 8'h00, 4'd0, 3'd0, 1'b0, 1'b1};
        vecs[7] = vecs[0];

        if3.start = 1'b0; if3.expected = '0;
        if4.start = 1'b0; if4.expected = '0;

        @(negedge clk);
        check("rst_dut_in", if3.dut_in, 0);
        check("rst_busy", if3.busy, 0);
        check("rst_done", if3.done, 0);
        check("rst_pass", if3.pass, 0);
        check("rst_err_count", if3.err_count, 0);
        check("rst_first_err", {if3.first_err_vld, if3.first_err}, 0);
        check("rst_captured", if3.captured, 0);
        check("rst4_outputs", {if4.busy, if4.done, if4.dut_in, if4.err_count}, 0);
`ifdef TT_RESPONSE_CHECKER_MISR_EN
        check("rst_signature", sig3, 0);
`endif
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run3(vecs[i], i == 1, i == 2);
`ifdef TT_RESPONSE_CHECKER_MISR_EN
            if (i == 0) first_sig = sig3;
            if (i == 7) check("signature_repeat", sig3, first_sig);
`endif
        end

        // 4-input instance, 3-cycle settle, stuck-at-0 DUT.
        if4.expected = 16'h8001;
        if4.start    = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        cyc = 1;
        ok  = 1'b1;
        while (!if4.done && cyc < 400) begin
            if (if4.dut_in !== 4'((cyc - 1) / 4) || !if4.busy) ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("n4_latency", cyc, 65);
        check("n4_dut_in_seq", ok, 1);
        check("n4_err_count", if4.err_count, 2);
        check("n4_first_err", if4.first_err, 0);
        check("n4_first_err_vld", if4.first_err_vld, 1);
        check("n4_pass", if4.pass, 0);
        check("n4_captured", if4.captured, 0);
        @(negedge clk);

        // Reset in the middle of a sweep.
        fsel         = 2'd0;
        if3.expected = 8'h00;
        if3.start    = 1'b1;
        @(negedge clk);
        if3.start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset_busy", if3.busy, 1);
        check("pre_reset_err", if3.err_count, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_outputs", {if3.busy, if3.done, if3.pass, if3.first_err_vld}, 0);
        check("mid_rst_err_count", if3.err_count, 0);
        check("mid_rst_captured", if3.captured, 0);
        check("mid_rst_dut_in", if3.dut_in, 0);
        ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (if3.done || if3.busy) ok = 1'b0;
        end
        check("no_done_after_reset", ok, 1);
        run3(vecs[0], 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/tt_response_checker.md
Name: tt_response_checker

Overview:
- Synthesizable, self-running counterpart to the team's exhaustive truth-table benches for the `gates_*` combinational modules.
- The benches drive every input combination and print the output for a human to read. This block is the response side in hardware:
  - it sweeps the DUT inputs itself;
  - it samples the DUT output for each combination;
  - it assembles the captured truth table;
  - it compares that table with an expected minterm vector and reports pass/fail, mismatch count and the first failing index.
- It sits beside any 3- or 4-input `gates_*` module, on-board or in a top-level wrapper.

Parameters:
- N_IN, 4, number of DUT inputs (supported range 2..6); the truth table has 2**N_IN entries.
- SETTLE_CYC, 1, cycles `dut_in` is held stable before `dut_out` is sampled (must be >= 1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run a sweep; ignored while busy.
- expected  in  2**N_IN  expected truth table; bit i = expected Y for input index i, with A as MSB. Latched on an accepted start.
- dut_out  in  1  Y output of the DUT.
- dut_in  out  N_IN  registered input vector to the DUT, {A,B,C[,D]} with A as MSB.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  valid from done until the next accepted start; 1 iff err_count == 0.
- err_count  out  N_IN+1  number of mismatching entries (0..2**N_IN).
- first_err  out  N_IN  lowest mismatching index.
- first_err_vld  out  1  first_err holds a real value.
- captured  out  2**N_IN  sampled truth table.

Behaviour:
- Reset: every output 0, state IDLE, latched expected 0.
  - Reset is synchronous, so it takes effect on the next edge.
  - Reset asserted mid-sweep aborts the sweep with no done pulse; dut_in returns to 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On start: latch expected; clear idx, captured, err_count, first_err, first_err_vld and pass; load the settle counter with SETTLE_CYC; go to SETTLE.
  - start while busy has no effect.
- SETTLE:
  - dut_in = idx, registered.
  - Remains for exactly SETTLE_CYC cycles, then goes to SAMPLE.
- SAMPLE (one cycle):
  - captured[idx] <= dut_out.
  - If dut_out != expected_q[idx]: err_count increments; if first_err_vld is 0, first_err <= idx and first_err_vld <= 1.
  - If idx == 2**N_IN-1, go to DONE; otherwise idx increments, the settle counter reloads and the state returns to SETTLE.
  - dut_in changes only on the SETTLE entry edge.
- DONE (one cycle):
  - done = 1 and busy = 0; pass = (err_count == 0) including the final sample.
  - Returns to IDLE. Results hold until the next accepted start.
- Latency: start accepted at cycle 0 → done at cycle 2**N_IN*(SETTLE_CYC+1)+1.
  - Defaults (N_IN=4, SETTLE_CYC=1): done at cycle 33.
- Boundaries:
  - start in the same cycle as DONE is ignored.
  - start in the cycle after DONE (IDLE) is accepted.
  - err_count cannot wrap; its width covers 2**N_IN.
  - dut_out may be X before the first SETTLE ends; it is not sampled then.

Optional Feature:
- Macro: TT_RESPONSE_CHECKER_MISR_EN.
- When defined:
  - Extra port `signature`, out, 16 bits: a 16-bit MISR with polynomial x^16+x^12+x^5+1 and seed 16'hFFFF.
  - It is reseeded on an accepted start and shifts in dut_out in each SAMPLE cycle.
  - Final value is stable from done onward.
- When undefined: no `signature` port and no MISR logic; all other behaviour identical.

Decomposition:
- Package tt_check_pkg:
  - state enum (IDLE/SETTLE/SAMPLE/DONE);
  - MISR_POLY = 16'h1021;
  - MISR_SEED = 16'hFFFF.
- Sub-module tt_check_misr: 16-bit MISR with clk, reset, init, shift_en, din, sig. Instantiated only under the macro.

Test Plan:
- N_IN=3, DUT Y=A&B|C, expected=8'hEA, start → done at cycle 17, captured=8'hEA, pass=1, err_count=0, first_err_vld=0.
- Same DUT, expected=8'hEB → pass=0, err_count=1, first_err=0, first_err_vld=1; dut_in steps 0..7, each value held SETTLE_CYC+1 cycles.
- N_IN=4, SETTLE_CYC=3, DUT stuck at 0, expected=16'h8001 → err_count=2, first_err=0, done at cycle 65.
- start pulsed at cycles 5 and 20 during a sweep → ignored; exactly one done pulse; second start one cycle after done → new sweep, results cleared.
- reset asserted at cycle 10 mid-sweep → next cycle all outputs 0, no done; a new start runs a clean sweep.
- With TT_RESPONSE_CHECKER_MISR_EN, N_IN=3 sweep of the AB+C DUT → signature equals the bench's behavioural MISR model; reseed verified by a repeat sweep giving the identical value.
